operand_stack_unit: RTL and testbench

- Data-stack front end for the bytecode datapath: holds the evaluation stack and sequences binary operations into the ALU operand registers.
- Pops the top two entries onto a shared operand bus, loading regOp1 and then regOp2 in consecutive cycles.
- Captures the ALU result and pushes it back.
- Exports the stack pointer as the TOS value consumed by the ALU operand mux.

---
 rtl/operand_stack_unit_pkg.sv | 22 ++
 rtl/operand_stack_unit_if.sv | 35 +++
 rtl/operand_stack_regfile.sv | 33 +++
 rtl/operand_stack_unit.sv | 186 ++++++++++++++++++
 tb/tb_operand_stack_unit.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/operand_stack_unit_pkg.sv
// Shared encodings for the operand stack unit: command opcodes and FSM states.
package operand_stack_unit_pkg;

   typedef enum logic [2:0] {
      CMD_NOP   = 3'b000,
      CMD_PUSH  = 3'b001,
      CMD_POP   = 3'b010,
      CMD_DUP   = 3'b011,
      CMD_SWAP  = 3'b100,
      CMD_BINOP = 3'b101,
      CMD_CMPOP = 3'b110,
      CMD_RSVD  = 3'b111
   } cmd_op_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_OP1  = 2'd1,
      S_OP2  = 2'd2,
      S_EXEC = 2'd3
   } state_t;

endpackage

// File: rtl/operand_stack_unit_if.sv
// Command, ALU operand and status bundle between the bytecode controller and the stack unit.
interface operand_stack_unit_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 12,
   parameter int ULA_WIDTH  = 24
);
   logic                  CMD_VALID;
   logic [2:0]            CMD_OP;
   logic [DATA_WIDTH-1:0] PUSH_DATA;
   logic [ULA_WIDTH-1:0]  ULA_RESULT;
   logic                  CMD_READY;
   logic [DATA_WIDTH-1:0] OPND_OUT;
   logic                  LD_OP1;
   logic                  LD_OP2;
   logic                  EXEC;
   logic [DATA_WIDTH-1:0] TOP_DATA;
   logic [ADDR_WIDTH-1:0] TOS_OUT;
   logic                  EMPTY;
   logic                  FULL;
   logic                  ERR_UNDERFLOW;
   logic                  ERR_OVERFLOW;
   logic                  ERR_CLR;

   modport master (
      output CMD_VALID, CMD_OP, PUSH_DATA, ULA_RESULT, ERR_CLR,
      input  CMD_READY, OPND_OUT, LD_OP1, LD_OP2, EXEC, TOP_DATA, TOS_OUT,
             EMPTY, FULL, ERR_UNDERFLOW, ERR_OVERFLOW
   );

   modport slave (
      input  CMD_VALID, CMD_OP, PUSH_DATA, ULA_RESULT, ERR_CLR,
      output CMD_READY, OPND_OUT, LD_OP1, LD_OP2, EXEC, TOP_DATA, TOS_OUT,
             EMPTY, FULL, ERR_UNDERFLOW, ERR_OVERFLOW
   );
endinterface

// File: rtl/operand_stack_regfile.sv
// Stack storage: two combinational read ports (TOS, TOS1), one write port and an in-place swap.
module operand_stack_regfile #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic [DEPTH_LOG2-1:0] tos_idx,
   input  logic [DEPTH_LOG2-1:0] tos1_idx,
   output logic [DATA_WIDTH-1:0] rd_tos,
   output logic [DATA_WIDTH-1:0] rd_tos1,
   input  logic                  wr_en,
   input  logic [DEPTH_LOG2-1:0] wr_idx,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  swap_en
);
   localparam int DEPTH = 2 ** DEPTH_LOG2;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   assign rd_tos  = mem[tos_idx];
   assign rd_tos1 = mem[tos1_idx];

   // Storage is deliberately not reset; the stack pointer alone defines validity.
   always_ff @(posedge clk) begin
      if (swap_en) begin
         mem[tos_idx]  <= mem[tos1_idx];
         mem[tos1_idx] <= mem[tos_idx];
      end else if (wr_en) begin
         mem[wr_idx] <= wr_data;
      end
   end

endmodule

// File: rtl/operand_stack_unit.sv
// Evaluation stack with pointer/error tracking and the operand sequencer feeding the ALU registers.
module operand_stack_unit
   import operand_stack_unit_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 12,
   parameter int ULA_WIDTH  = 24,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   operand_stack_unit_if.slave  bus
);
   localparam int SP_W  = DEPTH_LOG2 + 1;
   localparam int DEPTH = 2 ** DEPTH_LOG2;

   localparam logic [SP_W-1:0]       SP_ONE  = SP_W'(1);
   localparam logic [SP_W-1:0]       SP_TWO  = SP_W'(2);
   localparam logic [SP_W-1:0]       SP_FULL = SP_W'(DEPTH);
   localparam logic [DEPTH_LOG2-1:0] IDX_ONE = DEPTH_LOG2'(1);
   localparam logic [DEPTH_LOG2-1:0] IDX_TWO = DEPTH_LOG2'(2);

   state_t                state;
   logic [SP_W-1:0]       sp;
   logic                  is_cmp;
   logic                  ld_op1;
   logic                  ld_op2;
   logic                  exec;
   logic [DATA_WIDTH-1:0] opnd;
   logic                  err_underflow;
   logic                  err_overflow;

   logic                  accept;
   cmd_op_t               op;
   logic                  empty;
   logic                  full;
   logic                  lt2;
   logic                  set_under;
   logic                  set_over;

   logic [DEPTH_LOG2-1:0] sp_idx;
   logic [DEPTH_LOG2-1:0] tos_idx;
   logic [DEPTH_LOG2-1:0] tos1_idx;
   logic [DATA_WIDTH-1:0] rd_tos;
   logic [DATA_WIDTH-1:0] rd_tos1;
   logic                  wr_en;
   logic [DEPTH_LOG2-1:0] wr_idx;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  swap_en;

   logic                  unused_ula_hi;

   assign op       = cmd_op_t'(bus.CMD_OP);
   assign accept   = bus.CMD_VALID && (state == S_IDLE);
   assign empty    = (sp == '0);
   assign full     = (sp == SP_FULL);
   assign lt2      = (sp < SP_TWO);
   assign sp_idx   = sp[DEPTH_LOG2-1:0];
   assign tos_idx  = sp_idx - IDX_ONE;
   assign tos1_idx = sp_idx - IDX_TWO;

   // Only the low byte of the ALU result is written back; upper bits are dropped.
   assign unused_ula_hi = ^bus.ULA_RESULT[ULA_WIDTH-1:DATA_WIDTH];

   operand_stack_regfile #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_regfile (
      .clk      (clk),
      .tos_idx  (tos_idx),
      .tos1_idx (tos1_idx),
      .rd_tos   (rd_tos),
      .rd_tos1  (rd_tos1),
      .wr_en    (wr_en),
      .wr_idx   (wr_idx),
      .wr_data  (wr_data),
      .swap_en  (swap_en)
   );

   // Storage write/swap requests and error detection for the current cycle.
   always_comb begin
      wr_en     = 1'b0;
      wr_idx    = sp_idx;
      wr_data   = bus.PUSH_DATA;
      swap_en   = 1'b0;
      set_under = 1'b0;
      set_over  = 1'b0;
      if (accept) begin
         case (op)
            CMD_PUSH: begin
               set_over = full;
               wr_en    = !full;
            end
            CMD_POP:  set_under = empty;
            CMD_DUP: begin
               set_over  = full;
               set_under = empty;
               wr_en     = !full && !empty;
               wr_data   = rd_tos;
            end
            CMD_SWAP: begin
               set_under = lt2;
               swap_en   = !lt2;
            end
            CMD_BINOP, CMD_CMPOP: set_under = lt2;
            default: ;
         endcase
      end
      if (state == S_EXEC && !is_cmp) begin
         wr_en   = 1'b1;
         wr_idx  = tos1_idx;
         wr_data = bus.ULA_RESULT[DATA_WIDTH-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         sp            <= '0;
         is_cmp        <= 1'b0;
         ld_op1        <= 1'b0;
         ld_op2        <= 1'b0;
         exec          <= 1'b0;
         opnd          <= '0;
         err_underflow <= 1'b0;
         err_overflow  <= 1'b0;
      end else begin
         ld_op1 <= 1'b0;
         ld_op2 <= 1'b0;
         exec   <= 1'b0;
         opnd   <= '0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  case (op)
                     CMD_PUSH: if (!full) sp <= sp + SP_ONE;
                     CMD_POP:  if (!empty) sp <= sp - SP_ONE;
                     CMD_DUP:  if (!full && !empty) sp <= sp + SP_ONE;
                     CMD_BINOP, CMD_CMPOP: begin
                        if (!lt2) begin
                           state  <= S_OP1;
                           is_cmp <= (op == CMD_CMPOP);
                           ld_op1 <= 1'b1;
                           opnd   <= rd_tos;
                        end
                     end
                     default: ;
                  endcase
               end
            end
            S_OP1: begin
               state  <= S_OP2;
               ld_op2 <= 1'b1;
               opnd   <= rd_tos1;
            end
            S_OP2: begin
               state <= S_EXEC;
               exec  <= 1'b1;
            end
            S_EXEC: begin
               state <= S_IDLE;
               sp    <= is_cmp ? (sp - SP_TWO) : (sp - SP_ONE);
            end
            default: state <= S_IDLE;
         endcase
         // A new fault in the same cycle as a clear leaves the flag set.
         if (set_over)         err_overflow  <= 1'b1;
         else if (bus.ERR_CLR) err_overflow  <= 1'b0;
         if (set_under)        err_underflow <= 1'b1;
         else if (bus.ERR_CLR) err_underflow <= 1'b0;
      end
   end

   assign bus.CMD_READY     = (state == S_IDLE);
   assign bus.OPND_OUT      = opnd;
   assign bus.LD_OP1        = ld_op1;
   assign bus.LD_OP2        = ld_op2;
   assign bus.EXEC          = exec;
   assign bus.TOP_DATA      = empty ? '0 : rd_tos;
   assign bus.TOS_OUT       = ADDR_WIDTH'(sp);
   assign bus.EMPTY         = empty;
   assign bus.FULL          = full;
   assign bus.ERR_UNDERFLOW = err_underflow;
   assign bus.ERR_OVERFLOW  = err_overflow;

endmodule

// File: tb/tb_operand_stack_unit.sv
// Scenario bench for operand_stack_unit with a reference stack model and an operand scoreboard.
module tb_operand_stack_unit;
   import operand_stack_unit_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;

   logic [7:0] model[$];
   logic [7:0] sb[$];

   operand_stack_unit_if #(.DATA_WIDTH(8), .ADDR_WIDTH(12), .ULA_WIDTH(24)) bus ();

   operand_stack_unit #(
      .DATA_WIDTH (8),
      .ADDR_WIDTH (12),
      .ULA_WIDTH  (24),
      .DEPTH_LOG2 (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] exp_top();
      return (model.size() > 0) ? model[$] : 8'h00;
   endfunction

   // Drive one command at a falling edge; it is accepted at the following rising edge.
   task automatic issue(input logic [2:0] op, input logic [7:0] d);
      bus.CMD_VALID = 1'b1;
      bus.CMD_OP    = op;
      bus.PUSH_DATA = d;
      @(negedge clk);
      bus.CMD_VALID = 1'b0;
      bus.CMD_OP    = 3'b000;
   endtask

   task automatic push(input logic [7:0] d);
      issue(CMD_PUSH, d);
      if (model.size() < 16) model.push_back(d);
   endtask

   task automatic pop();
      issue(CMD_POP, 8'h00);
      if (model.size() > 0) void'(model.pop_back());
   endtask

   // Runs a BINOP/CMPOP, scoreboarding operands and timing the EXEC pulse and ready return.
   task automatic run_alu(input logic [2:0] op, input logic [23:0] ula, input string name);
      int c;
      int exec_c;
      logic [7:0] exp;
      sb.push_back(model[$]);
      sb.push_back(model[$-1]);
      bus.ULA_RESULT = ula;
      issue(op, 8'h00);
      c = 1;
      exec_c = -1;
      while (!bus.CMD_READY && c < 10) begin
         if (bus.LD_OP1 || bus.LD_OP2) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL %s_extra_strobe cycle=%0d", name, c);
            end else begin
               exp = sb.pop_front();
               if (bus.OPND_OUT !== exp || bus.LD_OP1 !== (c == 1) || bus.LD_OP2 !== (c == 2)) begin
                  errors++;
                  $display("FAIL %s_operand cycle=%0d got=%h ld1=%b ld2=%b exp=%h", name, c,
                           bus.OPND_OUT, bus.LD_OP1, bus.LD_OP2, exp);
               end
            end
         end
         if (bus.EXEC) exec_c = c;
         @(negedge clk);
         c++;
      end
      checks++;
      if (c !== 4 || exec_c !== 3 || sb.size() != 0) begin
         errors++;
         $display("FAIL %s_timing ready_cycle=%0d exec_cycle=%0d left=%0d exp 4/3/0", name, c, exec_c,
                  sb.size());
         sb.delete();
      end
      void'(model.pop_back());
      void'(model.pop_back());
      if (op == CMD_BINOP) model.push_back(ula[7:0]);
      checks++;
      if (bus.TOS_OUT !== 12'(model.size()) || bus.TOP_DATA !== exp_top() || bus.EMPTY !== (model.size() == 0)) begin
         errors++;
         $display("FAIL %s_result tos=%0d top=%h empty=%b exp tos=%0d top=%h", name, bus.TOS_OUT,
                  bus.TOP_DATA, bus.EMPTY, model.size(), exp_top());
      end
   endtask

   task automatic test_reset();
      bus.CMD_VALID = 1'b0; bus.CMD_OP = 3'b000; bus.PUSH_DATA = 8'h00;
      bus.ULA_RESULT = 24'h0; bus.ERR_CLR = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (bus.TOS_OUT !== 12'd0 || bus.EMPTY !== 1'b1 || bus.LD_OP1 !== 1'b0 || bus.LD_OP2 !== 1'b0 ||
          bus.EXEC !== 1'b0 || bus.OPND_OUT !== 8'h00 || bus.ERR_OVERFLOW !== 1'b0 ||
          bus.ERR_UNDERFLOW !== 1'b0 || bus.TOP_DATA !== 8'h00) begin
         errors++;
         $display("FAIL reset_state tos=%0d empty=%b ld=%b%b exec=%b opnd=%h errs=%b%b", bus.TOS_OUT,
                  bus.EMPTY, bus.LD_OP1, bus.LD_OP2, bus.EXEC, bus.OPND_OUT, bus.ERR_OVERFLOW, bus.ERR_UNDERFLOW);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.CMD_READY !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready got=%b exp=1", bus.CMD_READY);
      end
   endtask

   task automatic test_push();
      push(8'h05);
      push(8'h03);
      checks++;
      if (bus.TOS_OUT !== 12'd2 || bus.TOP_DATA !== 8'h03 || bus.EMPTY !== 1'b0) begin
         errors++;
         $display("FAIL push_two tos=%0d top=%h empty=%b exp 2/03/0", bus.TOS_OUT, bus.TOP_DATA, bus.EMPTY);
      end
   endtask

   task automatic test_back_to_back();
      run_alu(CMD_BINOP, 24'h000002, "binop");
      push(8'h10);
      push(8'h20);
      run_alu(CMD_BINOP, 24'h0001FF, "binop_trunc");
      run_alu(CMD_CMPOP, 24'h0000AA, "cmpop");
   endtask

   task automatic test_swap_dup();
      push(8'h11);
      push(8'h22);
      issue(CMD_SWAP, 8'h00);
      checks++;
      if (bus.TOP_DATA !== 8'h11 || bus.TOS_OUT !== 12'd2) begin
         errors++;
         $display("FAIL swap_top top=%h tos=%0d exp 11/2", bus.TOP_DATA, bus.TOS_OUT);
      end
      issue(CMD_POP, 8'h00);
      checks++;
      if (bus.TOP_DATA !== 8'h22) begin
         errors++;
         $display("FAIL swap_second top=%h exp 22", bus.TOP_DATA);
      end
      issue(CMD_DUP, 8'h00);
      issue(3'b111, 8'h99);
      checks++;
      if (bus.TOP_DATA !== 8'h22 || bus.TOS_OUT !== 12'd2 || bus.ERR_UNDERFLOW !== 1'b0 ||
          bus.ERR_OVERFLOW !== 1'b0) begin
         errors++;
         $display("FAIL dup_top top=%h tos=%0d exp 22/2", bus.TOP_DATA, bus.TOS_OUT);
      end
      model.delete();
      model.push_back(8'h22);
      model.push_back(8'h22);
      pop();
      pop();
   endtask

   task automatic test_errors();
      for (int i = 0; i < 16; i++) push(8'(i + 1));
      checks++;
      if (bus.FULL !== 1'b1 || bus.TOS_OUT !== 12'd16 || bus.ERR_OVERFLOW !== 1'b0) begin
         errors++;
         $display("FAIL fill full=%b tos=%0d ovf=%b exp 1/16/0", bus.FULL, bus.TOS_OUT, bus.ERR_OVERFLOW);
      end
      push(8'hEE);
      checks++;
      if (bus.ERR_OVERFLOW !== 1'b1 || bus.TOS_OUT !== 12'd16 || bus.TOP_DATA !== 8'h10) begin
         errors++;
         $display("FAIL overflow ovf=%b tos=%0d top=%h exp 1/16/10", bus.ERR_OVERFLOW, bus.TOS_OUT, bus.TOP_DATA);
      end
      bus.ERR_CLR = 1'b1; @(negedge clk); bus.ERR_CLR = 1'b0;
      checks++;
      if (bus.ERR_OVERFLOW !== 1'b0) begin
         errors++;
         $display("FAIL overflow_clr got=%b exp=0", bus.ERR_OVERFLOW);
      end
      for (int i = 0; i < 16; i++) pop();
      pop();
      checks++;
      if (bus.ERR_UNDERFLOW !== 1'b1 || bus.TOS_OUT !== 12'd0 || bus.TOP_DATA !== 8'h00) begin
         errors++;
         $display("FAIL underflow unf=%b tos=%0d top=%h exp 1/0/00", bus.ERR_UNDERFLOW, bus.TOS_OUT, bus.TOP_DATA);
      end
      bus.ERR_CLR = 1'b1; @(negedge clk);
      checks++;
      if (bus.ERR_UNDERFLOW !== 1'b0) begin
         errors++;
         $display("FAIL underflow_clr got=%b exp=0", bus.ERR_UNDERFLOW);
      end
      pop();
      bus.ERR_CLR = 1'b0;
      checks++;
      if (bus.ERR_UNDERFLOW !== 1'b1) begin
         errors++;
         $display("FAIL set_beats_clr got=%b exp=1", bus.ERR_UNDERFLOW);
      end
      bus.ERR_CLR = 1'b1; @(negedge clk); bus.ERR_CLR = 1'b0;
      push(8'h44);
      issue(CMD_BINOP, 8'h00);
      checks++;
      if (bus.ERR_UNDERFLOW !== 1'b1 || bus.CMD_READY !== 1'b1 || bus.LD_OP1 !== 1'b0 ||
          bus.TOS_OUT !== 12'd1 || bus.TOP_DATA !== 8'h44) begin
         errors++;
         $display("FAIL binop_short unf=%b rdy=%b ld1=%b tos=%0d top=%h exp 1/1/0/1/44", bus.ERR_UNDERFLOW,
                  bus.CMD_READY, bus.LD_OP1, bus.TOS_OUT, bus.TOP_DATA);
      end
      pop();
   endtask

   task automatic test_reset_mid();
      logic [7:0] exp;
      push(8'h05);
      push(8'h03);
      sb.push_back(8'h03);
      sb.push_back(8'h05);
      bus.ULA_RESULT = 24'h0000AA;
      issue(CMD_BINOP, 8'h00);
      exp = sb.pop_front();
      checks++;
      if (bus.LD_OP1 !== 1'b1 || bus.OPND_OUT !== exp) begin
         errors++;
         $display("FAIL mid_op1 ld1=%b opnd=%h exp 1/%h", bus.LD_OP1, bus.OPND_OUT, exp);
      end
      @(negedge clk);
      exp = sb.pop_front();
      checks++;
      if (bus.LD_OP2 !== 1'b1 || bus.OPND_OUT !== exp) begin
         errors++;
         $display("FAIL mid_op2 ld2=%b opnd=%h exp 1/%h", bus.LD_OP2, bus.OPND_OUT, exp);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (bus.LD_OP2 !== 1'b0 || bus.TOS_OUT !== 12'd0 || bus.CMD_READY !== 1'b1 || bus.OPND_OUT !== 8'h00) begin
         errors++;
         $display("FAIL mid_reset ld2=%b tos=%0d rdy=%b opnd=%h exp 0/0/1/00", bus.LD_OP2, bus.TOS_OUT,
                  bus.CMD_READY, bus.OPND_OUT);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model.delete();
      @(negedge clk);
      checks++;
      if (bus.EXEC !== 1'b0 || bus.CMD_READY !== 1'b1 || bus.EMPTY !== 1'b1 || bus.TOP_DATA !== 8'h00) begin
         errors++;
         $display("FAIL mid_release exec=%b rdy=%b empty=%b top=%h exp 0/1/1/00", bus.EXEC, bus.CMD_READY,
                  bus.EMPTY, bus.TOP_DATA);
      end
      push(8'h77);
      checks++;
      if (bus.TOS_OUT !== 12'd1 || bus.TOP_DATA !== 8'h77) begin
         errors++;
         $display("FAIL mid_after_push tos=%0d top=%h exp 1/77", bus.TOS_OUT, bus.TOP_DATA);
      end
   endtask

   initial begin
      test_reset();
      test_push();
      test_back_to_back();
      test_swap_dup();
      test_errors();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
